// File: rtl/bp_update_sched_if.sv
// Signal bundle between the F/M pipeline and the branch predictor update sequencer.
// The pipeline side uses the master modport; the sequencer uses the slave modport.
interface bp_update_sched_if #(
    parameter int PHT_DEPTH = 6,
    parameter int BHT_DEPTH = 10
);
    logic                 pred_req_i;
    logic [BHT_DEPTH-1:0] pred_idx_i;
    logic [PHT_DEPTH-1:0] pred_ghr_i;
    logic                 pred_g_i;
    logic                 pred_l_i;
    logic                 pred_choose_i;
    logic                 kill_i;
    logic                 res_valid_i;
    logic                 res_taken_i;
    logic                 res_ready_o;
    logic                 stall_o;
    logic                 init_busy_o;
    logic                 mispredict_o;
    logic [PHT_DEPTH-1:0] ghr_restore_o;
    logic                 wr_en_o;
    logic                 wr_init_o;
    logic [BHT_DEPTH-1:0] wr_bht_idx_o;
    logic [PHT_DEPTH-1:0] wr_ghr_o;
    logic                 wr_taken_o;
    logic                 wr_gcorr_o;
    logic                 wr_lcorr_o;
    logic                 protocol_err_o;

    modport master (
        output pred_req_i, pred_idx_i, pred_ghr_i, pred_g_i, pred_l_i, pred_choose_i,
               kill_i, res_valid_i, res_taken_i,
        input  res_ready_o, stall_o, init_busy_o, mispredict_o, ghr_restore_o,
               wr_en_o, wr_init_o, wr_bht_idx_o, wr_ghr_o, wr_taken_o, wr_gcorr_o,
               wr_lcorr_o, protocol_err_o
    );

    modport slave (
        input  pred_req_i, pred_idx_i, pred_ghr_i, pred_g_i, pred_l_i, pred_choose_i,
               kill_i, res_valid_i, res_taken_i,
        output res_ready_o, stall_o, init_busy_o, mispredict_o, ghr_restore_o,
               wr_en_o, wr_init_o, wr_bht_idx_o, wr_ghr_o, wr_taken_o, wr_gcorr_o,
               wr_lcorr_o, protocol_err_o
    );
endinterface

// File: rtl/bp_update_sched.sv
// Tournament predictor table sequencer: in-flight branch tracking, mispredict/GHR repair,
// and arbitration of the single table write port between the init sweep and M-stage updates.
module bp_update_sched #(
    parameter int PHT_DEPTH = 6,
    parameter int BHT_DEPTH = 10,
    parameter int IQ_DEPTH  = 4,
    parameter int UQ_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             rst,
    bp_update_sched_if.slave bus
);
    // state  | meaning
    // S_INIT | sweeping every BHT/PHT/chooser index with its reset value
    // S_RUN  | tracking branches and draining queued table updates
    typedef enum logic {S_INIT, S_RUN} state_t;

    localparam int IQ_PW = $clog2(IQ_DEPTH);
    localparam int UQ_PW = $clog2(UQ_DEPTH);

    typedef struct packed {
        logic [BHT_DEPTH-1:0] idx;
        logic [PHT_DEPTH-1:0] ghr;
        logic                 g;
        logic                 l;
        logic                 choose;
    } iq_entry_t;

    typedef struct packed {
        logic [BHT_DEPTH-1:0] idx;
        logic [PHT_DEPTH-1:0] ghr;
        logic                 taken;
        logic                 gcorr;
        logic                 lcorr;
    } uq_entry_t;

    state_t               state_q, state_d;
    logic [BHT_DEPTH-1:0] init_cnt_q, init_cnt_d;

    iq_entry_t            iq_mem_q [IQ_DEPTH];
    iq_entry_t            iq_mem_d [IQ_DEPTH];
    logic [IQ_PW-1:0]     iq_head_q, iq_head_d, iq_tail_q, iq_tail_d;
    logic [IQ_PW:0]       iq_cnt_q, iq_cnt_d;

    uq_entry_t            uq_mem_q [UQ_DEPTH];
    uq_entry_t            uq_mem_d [UQ_DEPTH];
    logic [UQ_PW-1:0]     uq_head_q, uq_head_d, uq_tail_q, uq_tail_d;
    logic [UQ_PW:0]       uq_cnt_q, uq_cnt_d;

    logic                 mispredict_q, mispredict_d;
    logic [PHT_DEPTH-1:0] ghr_restore_q, ghr_restore_d;
    logic                 perr_q, perr_d;
    logic                 wr_en_q, wr_en_d;
    uq_entry_t            wr_q, wr_d;

    logic                 run, init_busy, iq_full, uq_full, res_ready;
    logic                 pop, mis, kill_eff, push, drain, final_dir;
    logic [IQ_PW:0]       space_cnt;
    logic [IQ_PW-1:0]     wr_slot;
    iq_entry_t            head;

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        unique case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == '1) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: ;
            default: state_d = S_INIT;
        endcase
    end

    always_comb begin
        run       = (state_q == S_RUN);
        init_busy = (state_q == S_INIT);
        iq_full   = (iq_cnt_q == (IQ_PW+1)'(IQ_DEPTH));
        uq_full   = (uq_cnt_q == (UQ_PW+1)'(UQ_DEPTH));
        res_ready = run && !uq_full;

        head      = iq_mem_q[iq_head_q];
        final_dir = head.choose ? head.l : head.g;
        pop       = bus.res_valid_i && res_ready && (iq_cnt_q != '0);
        mis       = pop && (final_dir != bus.res_taken_i);
        // A kill cannot take the entry that is being resolved in the same cycle
        kill_eff  = run && bus.kill_i && (iq_cnt_q > (IQ_PW+1)'(pop));
        space_cnt = iq_cnt_q - (IQ_PW+1)'(kill_eff);
        push      = run && bus.pred_req_i && (space_cnt < (IQ_PW+1)'(IQ_DEPTH));
        wr_slot   = iq_tail_q - IQ_PW'(kill_eff);

        iq_mem_d  = iq_mem_q;
        if (mis) begin
            iq_head_d = iq_tail_q;
            iq_tail_d = iq_tail_q;
            iq_cnt_d  = '0;
        end else begin
            iq_head_d = iq_head_q + IQ_PW'(pop);
            iq_tail_d = wr_slot + IQ_PW'(push);
            iq_cnt_d  = iq_cnt_q - (IQ_PW+1)'(pop) - (IQ_PW+1)'(kill_eff) + (IQ_PW+1)'(push);
            if (push) begin
                iq_mem_d[wr_slot] = '{idx: bus.pred_idx_i, ghr: bus.pred_ghr_i, g: bus.pred_g_i,
                                      l: bus.pred_l_i, choose: bus.pred_choose_i};
            end
        end

        drain    = run && (uq_cnt_q != '0);
        uq_mem_d = uq_mem_q;
        if (pop) begin
            uq_mem_d[uq_tail_q] = '{idx: head.idx, ghr: head.ghr, taken: bus.res_taken_i,
                                    gcorr: head.g == bus.res_taken_i,
                                    lcorr: head.l == bus.res_taken_i};
        end
        uq_head_d = uq_head_q + UQ_PW'(drain);
        uq_tail_d = uq_tail_q + UQ_PW'(pop);
        uq_cnt_d  = uq_cnt_q + (UQ_PW+1)'(pop) - (UQ_PW+1)'(drain);

        wr_en_d = drain;
        wr_d    = drain ? uq_mem_q[uq_head_q] : wr_q;

        mispredict_d  = mis;
        ghr_restore_d = mis ? {head.ghr[PHT_DEPTH-2:0], bus.res_taken_i} : ghr_restore_q;
        perr_d        = perr_q || (run && (iq_cnt_q == '0) && (bus.res_valid_i || bus.kill_i));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_INIT;
            init_cnt_q    <= '0;
            iq_head_q     <= '0;
            iq_tail_q     <= '0;
            iq_cnt_q      <= '0;
            uq_head_q     <= '0;
            uq_tail_q     <= '0;
            uq_cnt_q      <= '0;
            mispredict_q  <= 1'b0;
            ghr_restore_q <= '0;
            perr_q        <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_q          <= '0;
        end else begin
            state_q       <= state_d;
            init_cnt_q    <= init_cnt_d;
            iq_head_q     <= iq_head_d;
            iq_tail_q     <= iq_tail_d;
            iq_cnt_q      <= iq_cnt_d;
            uq_head_q     <= uq_head_d;
            uq_tail_q     <= uq_tail_d;
            uq_cnt_q      <= uq_cnt_d;
            mispredict_q  <= mispredict_d;
            ghr_restore_q <= ghr_restore_d;
            perr_q        <= perr_d;
            wr_en_q       <= wr_en_d;
            wr_q          <= wr_d;
        end
    end

    // Queue storage needs no reset: occupancy is governed by the counts alone
    always_ff @(posedge clk) begin
        iq_mem_q <= iq_mem_d;
        uq_mem_q <= uq_mem_d;
    end

    // The init sweep owns the write port outright; its values bypass the update registers
    assign bus.wr_en_o        = init_busy || wr_en_q;
    assign bus.wr_init_o      = init_busy;
    assign bus.wr_bht_idx_o   = init_busy ? init_cnt_q : wr_q.idx;
    assign bus.wr_ghr_o       = init_busy ? init_cnt_q[PHT_DEPTH-1:0] : wr_q.ghr;
    assign bus.wr_taken_o     = !init_busy && wr_q.taken;
    assign bus.wr_gcorr_o     = !init_busy && wr_q.gcorr;
    assign bus.wr_lcorr_o     = !init_busy && wr_q.lcorr;
    assign bus.res_ready_o    = res_ready;
    assign bus.stall_o        = init_busy || iq_full;
    assign bus.init_busy_o    = init_busy;
    assign bus.mispredict_o   = mispredict_q;
    assign bus.ghr_restore_o  = ghr_restore_q;
    assign bus.protocol_err_o = perr_q;
endmodule

// File: tb/tb_bp_update_sched.sv
// Randomized scoreboard bench for bp_update_sched: a queue-level reference model predicts
// table writes and mispredict pulses, and a negedge monitor compares them as they appear.
module tb_bp_update_sched;
    localparam int PHT = 6;
    localparam int BHT = 10;
    localparam int IQD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bp_update_sched_if #(.PHT_DEPTH(PHT), .BHT_DEPTH(BHT)) ifc ();

    bp_update_sched #(.PHT_DEPTH(PHT), .BHT_DEPTH(BHT), .IQ_DEPTH(IQD), .UQ_DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    typedef struct {
        logic [BHT-1:0] idx;
        logic [PHT-1:0] ghr;
        logic g, l, ch;
    } br_t;
    typedef struct {
        int cyc;
        logic [BHT-1:0] idx;
        logic [PHT-1:0] ghr;
        logic taken, gc, lc;
    } wr_t;
    typedef struct {
        int cyc;
        logic [PHT-1:0] ghr;
    } mp_t;

    br_t inflight[$];
    wr_t exp_wr[$];
    mp_t exp_mp[$];
    bit  model_perr;
    int  cyc = 0;
    int  n_tests = 0;
    int  n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: every update write and mispredict pulse must match the oldest prediction
    always @(negedge clk) begin
        wr_t w;
        mp_t m;
        if (!rst) begin
            if (ifc.wr_en_o && !ifc.wr_init_o) begin
                chk("wr_expected", 32'(exp_wr.size() > 0), 32'd1);
                if (exp_wr.size() > 0) begin
                    w = exp_wr.pop_front();
                    chk("wr_cycle", cyc, w.cyc);
                    chk("wr_idx", 32'(ifc.wr_bht_idx_o), 32'(w.idx));
                    chk("wr_ghr", 32'(ifc.wr_ghr_o), 32'(w.ghr));
                    chk("wr_flags", 32'({ifc.wr_taken_o, ifc.wr_gcorr_o, ifc.wr_lcorr_o}),
                        32'({w.taken, w.gc, w.lc}));
                end
            end
            if (ifc.mispredict_o) begin
                chk("mp_expected", 32'(exp_mp.size() > 0), 32'd1);
                if (exp_mp.size() > 0) begin
                    m = exp_mp.pop_front();
                    chk("mp_cycle", cyc, m.cyc);
                    chk("ghr_restore", 32'(ifc.ghr_restore_o), 32'(m.ghr));
                end
            end
            if (exp_wr.size() > 0 && exp_wr[0].cyc < cyc) begin
                chk("wr_missing", cyc, exp_wr[0].cyc);
                void'(exp_wr.pop_front());
            end
            if (exp_mp.size() > 0 && exp_mp[0].cyc < cyc) begin
                chk("mp_missing", cyc, exp_mp[0].cyc);
                void'(exp_mp.pop_front());
            end
        end
    end

    task automatic set_idle();
        ifc.pred_req_i = 0; ifc.pred_idx_i = '0; ifc.pred_ghr_i = '0;
        ifc.pred_g_i = 0; ifc.pred_l_i = 0; ifc.pred_choose_i = 0;
        ifc.kill_i = 0; ifc.res_valid_i = 0; ifc.res_taken_i = 0;
    endtask

    // One S_RUN cycle: apply inputs, check status, then advance the reference model
    task automatic drive(input bit req, input logic [BHT-1:0] idx, input logic [PHT-1:0] ghr,
                         input bit g, input bit l, input bit ch,
                         input bit kill, input bit rv, input bit taken);
        int  sz;
        bit  pop, fin, flushed, kill_eff;
        br_t e;
        ifc.pred_req_i = req; ifc.pred_idx_i = idx; ifc.pred_ghr_i = ghr;
        ifc.pred_g_i = g; ifc.pred_l_i = l; ifc.pred_choose_i = ch;
        ifc.kill_i = kill; ifc.res_valid_i = rv; ifc.res_taken_i = taken;
        sz = inflight.size();
        @(negedge clk);
        chk("stall", 32'(ifc.stall_o), 32'(sz == IQD));
        chk("res_ready", 32'(ifc.res_ready_o), 32'd1);
        chk("protocol_err", 32'(ifc.protocol_err_o), 32'(model_perr));
        chk("init_busy", 32'(ifc.init_busy_o), 32'd0);
        if ((rv || kill) && sz == 0) model_perr = 1;
        pop = rv && sz > 0;
        flushed = 0;
        fin = 0;
        if (pop) begin
            e = inflight.pop_front();
            fin = e.ch ? e.l : e.g;
            exp_wr.push_back('{cyc + 2, e.idx, e.ghr, taken, e.g == taken, e.l == taken});
            if (fin != taken) begin
                exp_mp.push_back('{cyc + 1, {e.ghr[PHT-2:0], taken}});
                inflight.delete();
                flushed = 1;
            end
        end
        if (!flushed) begin
            kill_eff = kill && (sz - int'(pop)) > 0;
            if (kill_eff) void'(inflight.pop_back());
            if (req && (sz - int'(kill_eff)) < IQD) inflight.push_back('{idx, ghr, g, l, ch});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, '0, '0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push_br(input logic [BHT-1:0] idx, input logic [PHT-1:0] ghr,
                           input bit g, input bit l, input bit ch);
        drive(1, idx, ghr, g, l, ch, 0, 0, 0);
    endtask

    task automatic resolve(input bit taken);
        drive(0, '0, '0, 0, 0, 0, 0, 1, taken);
    endtask

    // Reset, then check the init sweep; stop_at >= 0 returns right after that index is seen
    task automatic reset_sweep(input int stop_at);
        logic [25:0] act, exp;
        rst = 1;
        set_idle();
        inflight.delete(); exp_wr.delete(); exp_mp.delete();
        model_perr = 0;
        @(posedge clk);
        #1;
        rst = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            act = {ifc.init_busy_o, ifc.wr_en_o, ifc.wr_init_o, ifc.stall_o, ifc.res_ready_o,
                   ifc.wr_taken_o, ifc.wr_gcorr_o, ifc.wr_lcorr_o, ifc.mispredict_o,
                   ifc.protocol_err_o, ifc.wr_bht_idx_o, ifc.wr_ghr_o};
            exp = {5'b11110, 5'b00000, 10'(i), 6'(i)};
            chk("init_sweep", 32'(act), 32'(exp));
            if (i == stop_at) return;
            ifc.pred_req_i  = 1'($urandom_range(0, 1));
            ifc.res_valid_i = 1'($urandom_range(0, 1));
            ifc.pred_idx_i  = 10'($urandom);
        end
        @(negedge clk);
        set_idle();
        chk("init_done", 32'({ifc.init_busy_o, ifc.stall_o, ifc.wr_en_o, ifc.res_ready_o}),
            32'(4'b0001));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        set_idle();
        reset_sweep(-1);

        push_br(10'd5, 6'h2A, 1, 0, 0);
        resolve(1);
        idle(3);

        push_br(10'd100, 6'h01, 0, 1, 1);
        push_br(10'd101, 6'h11, 1, 1, 0);
        push_br(10'd102, 6'h22, 0, 0, 1);
        resolve(0);
        push_br(10'd9, 6'h3F, 1, 1, 0);
        resolve(1);
        idle(3);

        for (int i = 0; i < 4; i++) push_br(10'(10 + i), 6'(i), 1, 1, 0);
        push_br(10'd14, 6'h15, 0, 1, 1);
        drive(1, 10'd14, 6'h15, 0, 1, 1, 1, 0, 0);
        for (int i = 0; i < 4; i++) resolve(1);
        idle(3);

        for (int n = 0; n < 2000; n++) begin
            int  sz;
            bit  req, kill, rv;
            sz   = inflight.size();
            req  = 1'($urandom_range(0, 1));
            kill = (sz > 0) && ($urandom_range(0, 6) == 0);
            rv   = (sz > 0) && ($urandom_range(0, 2) == 0);
            drive(req, 10'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  kill, rv, 1'($urandom));
        end

        push_br(10'd7, 6'h07, 1, 1, 0);
        reset_sweep(500);
        reset_sweep(-1);
        idle(4);

        resolve(1);
        idle(3);
        push_br(10'd33, 6'h0C, 0, 0, 1);
        resolve(0);
        idle(4);

        chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        chk("mp_queue_drained", 32'(exp_mp.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
